// File: rtl/weight_mux_ctrl_if.sv
// Handshake/bus bundle for the weight mux job sequencer.
// master = job/descriptor source and consumer of the mux drive; slave = sequencer.
interface weight_mux_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              mod_cfg;
    logic [CNT_W-1:0]  num_groups;
    logic [ADDR_W-1:0] base_addr;
    logic              hold;
    logic              desc_valid;
    logic [6:0]        desc_data;
    logic              desc_ready;
    logic              wgt_rd_en;
    logic [ADDR_W-1:0] wgt_rd_addr;
    logic              sel;
    logic              mod;
    logic [5:0]        addr;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, mod_cfg, num_groups, base_addr, hold, desc_valid, desc_data,
        input  desc_ready, wgt_rd_en, wgt_rd_addr, sel, mod, addr,
               out_valid, out_last, busy, done
    );

    modport slave (
        input  start, mod_cfg, num_groups, base_addr, hold, desc_valid, desc_data,
        output desc_ready, wgt_rd_en, wgt_rd_addr, sel, mod, addr,
               out_valid, out_last, busy, done
    );
endinterface

// File: rtl/weight_mux_ctrl.sv
// Job sequencer for the mixed-precision weight mux: walks N weight groups out of
// SRAM, pops one outlier descriptor per group, drives mux sel/mod/addr in step with
// SRAM read data and tags the mux output after the mux pipeline delay.
module weight_mux_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MUX_LAT    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    weight_mux_ctrl_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW    = MUX_LAT + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              mod_cfg_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  grp_cnt_q;
    logic [ADDR_W-1:0] base_q;

    logic              issue, last_issue, pipe_empty;
    logic              busy, done;

    // descriptor FIFO
    logic [6:0]        fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    cnt_q;
    logic              fifo_empty, fifo_full, push, pop;
    logic [6:0]        head;

    // mux drive stage (aligned with SRAM read data) and output tag pipes
    logic              sel_q, mod_q;
    logic [5:0]        addr_q;
    logic [MUX_LAT:0]  vld_pipe_q, last_pipe_q;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign head       = fifo_mem_q[rd_ptr_q];
    // A pop frees a slot only at the clock edge, so a full FIFO refuses the push.
    assign push       = bus.desc_valid && !fifo_full;
    assign pop        = issue && !mod_cfg_q;
    assign last_issue = issue && (grp_cnt_q == num_q - CNT_W'(1));
    assign pipe_empty = (vld_pipe_q == '0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.num_groups == '0) ? DONE : RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (pipe_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: issue gating, busy and done
    always_comb begin
        issue = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        case (state_q)
            IDLE:    busy  = 1'b0;
            RUN:     issue = !bus.hold && (mod_cfg_q || !fifo_empty);
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    // Job parameters latched at start; group counter advances per issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_cfg_q <= 1'b0;
            num_q     <= '0;
            base_q    <= '0;
            grp_cnt_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            mod_cfg_q <= bus.mod_cfg;
            num_q     <= bus.num_groups;
            base_q    <= bus.base_addr;
            grp_cnt_q <= '0;
        end else if (issue) begin
            grp_cnt_q <= grp_cnt_q + CNT_W'(1);
        end
    end

    // FIFO pointers and occupancy; pointers wrap with the power-of-2 depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= bus.desc_data;
    end

    // Mux drive, registered so it lines up with SRAM data one cycle after issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 1'b0;
            mod_q  <= 1'b0;
            addr_q <= '0;
        end else if (issue) begin
            if (mod_cfg_q) begin
                mod_q  <= 1'b1;
                sel_q  <= 1'b0;
                addr_q <= '0;
            end else begin
                mod_q  <= 1'b0;
                sel_q  <= head[6];
                addr_q <= head[6] ? head[5:0] : 6'd0;
            end
        end else begin
            sel_q <= 1'b0;
            mod_q <= 1'b0;
        end
    end

    // Output tag pipes: issue and last-issue delayed MUX_LAT+1 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            vld_pipe_q  <= (vld_pipe_q << 1)  | PW'(issue);
            last_pipe_q <= (last_pipe_q << 1) | PW'(last_issue);
        end
    end

    assign bus.desc_ready  = !fifo_full;
    assign bus.wgt_rd_en   = issue;
    assign bus.wgt_rd_addr = issue ? base_q + ADDR_W'(grp_cnt_q) : '0;
    assign bus.sel         = sel_q;
    assign bus.mod         = mod_q;
    assign bus.addr        = addr_q;
    assign bus.out_valid   = vld_pipe_q[MUX_LAT];
    assign bus.out_last    = last_pipe_q[MUX_LAT];
    assign bus.busy        = busy;
    assign bus.done        = done;
endmodule

// File: tb/tb_weight_mux_ctrl.sv
// Directed bench for weight_mux_ctrl: a table of single-group jobs plus
// hand-written multi-cycle sequences (plain, outlier, full FIFO, starvation,
// zero-length/ignored start, reset mid-job).
module tb_weight_mux_ctrl;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // running counts from the monitor
    int   rd_seen = 0, vld_seen = 0, last_seen = 0, done_seen = 0;
    logic last_of_vld = 1'b0;

    weight_mux_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    weight_mux_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DEPTH(4), .MUX_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wgt_rd_en) rd_seen++;
            if (bus.out_valid) begin
                vld_seen++;
                last_of_vld = bus.out_last;
            end
            if (bus.out_last) last_seen++;
            if (bus.done) done_seen++;
        end
    end

    typedef struct {
        logic       mcfg;
        logic [6:0] desc;
        logic [9:0] base;
        logic       exp_sel;
        logic       exp_mod;
        logic [5:0] exp_addr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // inputs change 1ns after the rising edge; outputs are sampled on the falling edge
    task automatic slot();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push1(input logic [6:0] d);
        slot();
        bus.desc_valid = 1'b1;
        bus.desc_data  = d;
        smp();
        chk("push_ready", bus.desc_ready, 1);
        slot();
        bus.desc_valid = 1'b0;
    endtask

    // returns in the first cycle after IDLE, before its sample point
    task automatic start_job(input logic mcfg, input logic [7:0] n, input logic [9:0] base);
        slot();
        bus.start      = 1'b1;
        bus.mod_cfg    = mcfg;
        bus.num_groups = n;
        bus.base_addr  = base;
        smp();
        slot();
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            smp();
            if (bus.done) found = 1'b1;
            slot();
            if (found) break;
        end
        chk("done_within_bound", 32'(found), 1);
    endtask

    task automatic run_plain(input logic [9:0] base, input bit poke);
        logic [9:0] ea;
        start_job(1'b1, 8'd3, base);
        for (int k = 0; k < 9; k++) begin
            smp();
            chk("plain_rd_en", bus.wgt_rd_en, (k < 3) ? 1 : 0);
            if (k < 3) begin
                ea = base + 10'(k);
                chk("plain_rd_addr", bus.wgt_rd_addr, ea);
            end
            if (k >= 1 && k <= 3) begin
                chk("plain_mod", bus.mod, 1);
                chk("plain_sel", bus.sel, 0);
            end
            chk("plain_out_valid", bus.out_valid, (k >= 3 && k <= 5) ? 1 : 0);
            chk("plain_out_last", bus.out_last, (k == 5) ? 1 : 0);
            chk("plain_done", bus.done, (k == 7) ? 1 : 0);
            slot();
            if (poke && k == 0) begin
                bus.start      = 1'b1;
                bus.num_groups = 8'd0;
            end
            if (k == 1) bus.start = 1'b0;
        end
    endtask

    initial begin
        vec_t vt[6];
        int   r0, v0, l0, d0;
        logic [6:0] fd[5];

        vt[0] = '{1'b1, 7'h00, 10'h3FF, 1'b0, 1'b1, 6'h00};
        vt[1] = '{1'b0, 7'h53, 10'h020, 1'b1, 1'b0, 6'h13};
        vt[2] = '{1'b0, 7'h7F, 10'h100, 1'b1, 1'b0, 6'h3F};
        vt[3] = '{1'b0, 7'h3F, 10'h155, 1'b0, 1'b0, 6'h00};
        vt[4] = '{1'b0, 7'h40, 10'h200, 1'b1, 1'b0, 6'h00};
        vt[5] = '{1'b0, 7'h65, 10'h001, 1'b1, 1'b0, 6'h25};
        fd = '{7'h41, 7'h4A, 7'h52, 7'h63, 7'h7C};

        bus.start = 0; bus.mod_cfg = 0; bus.num_groups = 0; bus.base_addr = 0;
        bus.hold = 0; bus.desc_valid = 0; bus.desc_data = 0;

        // reset state
        smp();
        chk("rst_desc_ready", bus.desc_ready, 1);
        chk("rst_rd_en", bus.wgt_rd_en, 0);
        chk("rst_rd_addr", bus.wgt_rd_addr, 0);
        chk("rst_sel_mod_addr", {bus.sel, bus.mod, bus.addr}, 0);
        chk("rst_tags", {bus.out_valid, bus.out_last, bus.busy, bus.done}, 0);
        slot();
        rst_n = 1'b1;

        // single-group jobs from the table
        for (int i = 0; i < 6; i++) begin
            if (!vt[i].mcfg) push1(vt[i].desc);
            start_job(vt[i].mcfg, 8'd1, vt[i].base);
            smp();
            chk("vec_rd_en", bus.wgt_rd_en, 1);
            chk("vec_rd_addr", bus.wgt_rd_addr, vt[i].base);
            slot(); smp();
            chk("vec_sel", bus.sel, vt[i].exp_sel);
            chk("vec_mod", bus.mod, vt[i].exp_mod);
            chk("vec_addr", bus.addr, vt[i].exp_addr);
            chk("vec_early_valid", bus.out_valid, 0);
            slot(); smp();
            chk("vec_idle_sel_mod", {bus.sel, bus.mod}, 0);
            chk("vec_addr_hold", bus.addr, vt[i].exp_addr);
            slot(); smp();
            chk("vec_out_valid", bus.out_valid, 1);
            chk("vec_out_last", bus.out_last, 1);
            slot(); smp();
            chk("vec_valid_drop", bus.out_valid, 0);
            slot(); smp();
            chk("vec_done", bus.done, 1);
            slot(); smp();
            chk("vec_idle_busy", bus.busy, 0);
            slot();
        end

        // plain 3-group job, and one that wraps the SRAM address with a stray start
        run_plain(10'h010, 1'b0);
        run_plain(10'h3FE, 1'b1);

        // outlier job
        push1(7'h53);
        push1(7'h00);
        start_job(1'b0, 8'd2, 10'h020);
        smp();
        chk("outl_rd_addr0", bus.wgt_rd_addr, 10'h020);
        slot(); smp();
        chk("outl_rd_addr1", bus.wgt_rd_addr, 10'h021);
        chk("outl_g0_sel", bus.sel, 1);
        chk("outl_g0_addr", bus.addr, 6'h13);
        slot(); smp();
        chk("outl_g1_sel", bus.sel, 0);
        chk("outl_g1_addr", bus.addr, 6'h00);
        chk("outl_g1_mod", bus.mod, 0);
        slot();
        wait_done();

        // full FIFO: 4 accepted (also proves it was empty), 5th held
        for (int i = 0; i < 5; i++) begin
            slot();
            bus.desc_valid = 1'b1;
            bus.desc_data  = fd[i];
            smp();
            chk("full_ready", bus.desc_ready, (i < 4) ? 1 : 0);
        end
        slot();
        bus.start = 1'b1; bus.mod_cfg = 1'b0; bus.num_groups = 8'd2; bus.base_addr = 10'h040;
        smp();
        slot();
        bus.start = 1'b0;
        smp();
        chk("full_pop_rd_en", bus.wgt_rd_en, 1);
        chk("full_pop_push_refused", bus.desc_ready, 0);
        slot(); smp();
        chk("full_ready_after_pop", bus.desc_ready, 1);
        chk("full_g0_addr", bus.addr, 6'h01);
        slot();
        bus.desc_valid = 1'b0;
        smp();
        chk("full_g1_addr", bus.addr, 6'h0A);
        slot();
        wait_done();
        start_job(1'b0, 8'd3, 10'h000);
        smp();
        chk("full_left_rd_en", bus.wgt_rd_en, 1);
        slot(); smp();
        chk("full_left_addr0", bus.addr, 6'h12);
        slot(); smp();
        chk("full_left_addr1", bus.addr, 6'h23);
        slot(); smp();
        chk("full_left_addr2", bus.addr, 6'h3C);
        slot();
        wait_done();

        // starvation: one descriptor, 5-cycle gap, then three more
        push1(7'h45);
        start_job(1'b0, 8'd4, 10'h100);
        r0 = rd_seen; v0 = vld_seen; l0 = last_seen; d0 = done_seen;
        smp();
        chk("starve_first_issue", bus.wgt_rd_en, 1);
        for (int g = 0; g < 5; g++) begin
            slot(); smp();
            chk("starve_gap_rd_en", bus.wgt_rd_en, 0);
        end
        slot();
        bus.desc_valid = 1'b1; bus.desc_data = 7'h41;
        slot();
        bus.desc_data = 7'h42;
        slot();
        bus.desc_data = 7'h43;
        slot();
        bus.desc_valid = 1'b0;
        wait_done();
        chk("starve_issues", rd_seen - r0, 4);
        chk("starve_valids", vld_seen - v0, 4);
        chk("starve_lasts", last_seen - l0, 1);
        chk("starve_last_on_final", last_of_vld, 1);
        chk("starve_dones", done_seen - d0, 1);

        // zero-length job
        r0 = rd_seen;
        start_job(1'b0, 8'd0, 10'h000);
        smp();
        chk("zero_done", bus.done, 1);
        chk("zero_busy", bus.busy, 1);
        slot(); smp();
        chk("zero_back_idle", {bus.busy, bus.done}, 0);
        chk("zero_no_rd", rd_seen - r0, 0);
        slot();

        // reset mid-job with two descriptors queued
        push1(7'h51);
        push1(7'h52);
        slot();
        bus.hold = 1'b1;
        start_job(1'b0, 8'd4, 10'h030);
        smp();
        chk("rstmid_busy", bus.busy, 1);
        d0 = done_seen;
        slot();
        rst_n = 1'b0;
        smp();
        chk("rstmid_ready", bus.desc_ready, 1);
        chk("rstmid_outs", {bus.wgt_rd_en, bus.sel, bus.mod, bus.addr, bus.out_valid,
                            bus.out_last, bus.busy, bus.done}, 0);
        slot();
        slot();
        rst_n = 1'b1;
        bus.hold = 1'b0;
        start_job(1'b0, 8'd1, 10'h030);
        for (int g = 0; g < 3; g++) begin
            smp();
            chk("rstmid_fifo_empty", bus.wgt_rd_en, 0);
            slot();
        end
        push1(7'h5A);
        smp();
        chk("rstmid_new_rd_en", bus.wgt_rd_en, 1);
        chk("rstmid_new_rd_addr", bus.wgt_rd_addr, 10'h030);
        slot(); smp();
        chk("rstmid_new_sel", bus.sel, 1);
        chk("rstmid_new_addr", bus.addr, 6'h1A);
        slot();
        wait_done();
        chk("rstmid_one_done", done_seen - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/weight_mux_ctrl.md
Name: weight_mux_ctrl

Overview:
- Job sequencer for the mixed-precision weight mux in the PE weight path.
- Per job it walks N weight groups (8 x 4-bit lanes each) out of weight SRAM and pops one outlier descriptor per group.
- It drives the mux `sel`/`mod`/`addr` in step with the SRAM read data, and tags mux output with `out_valid`/`out_last` after the mux pipeline delay.

Parameters:
- ADDR_W, 10, weight SRAM word address width
- CNT_W, 8, width of group count per job
- FIFO_DEPTH, 4, outlier descriptor FIFO entries (power of 2, >=2)
- MUX_LAT, 2, register stages from mux sel/addr input to mux weight output

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  job start pulse; sampled in IDLE only
- mod_cfg  in  1  1 = plain 4-bit job, descriptors not consumed
- num_groups  in  CNT_W  groups in job
- base_addr  in  ADDR_W  SRAM address of group 0
- hold  in  1  stall issue while high
- desc_valid  in  1  descriptor push valid
- desc_data  in  7  [6]=has_outlier, [5:3]=dest lane, [2:0]=cut lane
- desc_ready  out  1  = FIFO not full
- wgt_rd_en  out  1  SRAM read enable (data returns next cycle)
- wgt_rd_addr  out  ADDR_W  SRAM read address
- sel  out  1  to mux
- mod  out  1  to mux
- addr  out  6  to mux
- out_valid  out  1  mux weight_o0..7 valid this cycle
- out_last  out  1  with out_valid, last group of job
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset state:
  - All outputs 0 except `desc_ready`=1.
  - FSM enters IDLE; FIFO is flushed; counters are cleared.
  - Reset mid-job aborts the job with no `done`.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE:
    - On `start`, latch `mod_cfg`, `num_groups`, `base_addr`; clear group counter.
    - If `num_groups`==0, go to DONE; else go to RUN.
    - `start` outside IDLE is ignored.
  - RUN: issue fires when `!hold && (mod_cfg_q || FIFO non-empty)`.
    - Issue cycle t: `wgt_rd_en`=1, `wgt_rd_addr`=base_q+grp_cnt, grp_cnt++.
    - If `mod_cfg_q`=0, pop the FIFO head into a stage register.
    - Issue on the group with grp_cnt==num_q-1 moves the FSM to DRAIN.
  - DRAIN: stay until the valid pipe is empty, then go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
  - `busy`=1 in RUN, DRAIN and DONE.
- Mux drive (registered), valid in cycle t+1, aligned with SRAM data:
  - `mod_cfg_q`=1: `mod`=1, `sel`=0, `addr`=0.
  - Else: `mod`=0, `sel`=has_outlier, `addr`={dest, cut}.
  - has_outlier=0 forces `addr`=0.
  - Non-issue cycles: `sel`=0, `mod`=0, `addr` holds.
- Output tagging:
  - `out_valid` = issue delayed MUX_LAT+1 cycles (t+3 at default).
  - `out_last` = last-issue flag delayed identically.
  - No downstream backpressure.
- Descriptor FIFO:
  - Push when `desc_valid && desc_ready` in any state.
  - Simultaneous push and pop when full: push is refused (`desc_ready`=0 that cycle).
  - Push and pop on a non-empty FIFO in the same cycle: both succeed, count unchanged.
  - Pop on empty: never happens (issue is gated).
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - Leftover descriptors persist across jobs.
- `hold` or empty FIFO mid-job: no issue; bubbles appear on `out_valid`; order is preserved.
- `wgt_rd_addr` wraps modulo 2^ADDR_W.

Test Plan:
- Plain job:
  - Stimulus: `mod_cfg`=1, `num_groups`=3, `base_addr`=0x10, no descriptors.
  - Required: `wgt_rd_en` on 3 consecutive cycles with addr 0x10, 0x11, 0x12.
  - Required: `mod`=1, `sel`=0 at t+1; `out_valid` at t+3..t+5; `out_last` on the third; `done` 2 cycles after (after DRAIN).
- Outlier job:
  - Stimulus: `mod_cfg`=0, `num_groups`=2, descriptors 0x53 ({1,010,011}) then 0x00.
  - Required: group 0 `sel`=1, `addr`=0x13; group 1 `sel`=0, `addr`=0.
  - Required: FIFO empty after the job.
- Starvation:
  - Stimulus: `mod_cfg`=0, `num_groups`=4; push 1 descriptor, 5-cycle gap, push 3.
  - Required: one issue, then no `wgt_rd_en` for 5 cycles, then 3 issues.
  - Required: exactly 4 `out_valid` pulses, last one with `out_last`.
- FIFO full:
  - Stimulus: push 5 descriptors while IDLE, DEPTH=4.
  - Required: `desc_ready`=0 after the 4th; the 5th is held.
  - Required: after `start`, simultaneous pop and push on the full FIFO refuses the push.
- Zero and ignore:
  - Stimulus: `num_groups`=0 → required: IDLE to DONE, `done` pulse, no `wgt_rd_en`.
  - Stimulus: `start` pulsed during RUN → required: ignored.
- Reset mid-job:
  - Stimulus: drop `rst_n` in RUN with 2 FIFO entries.
  - Required: all outputs 0, `desc_ready`=1, FIFO empty, no `done`; a new job then runs normally.
